branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the instruction decoder's BranchInst, CondFlag[2:0] and FlagWrite outputs.
- Holds the architectural NZCV flag register, which is written by flag-setting compares.
- Evaluates the branch condition for the instruction in EX and computes the branch target.
- On a taken branch, drives the PC redirect and a bounded pipeline flush sequence through a small FSM.

Parameters:
- WIDTH, 32, PC/offset datapath width in bits.
- FLUSH_CYCLES, 2, cycles the FLUSH state suppresses branch evaluation after a redirect; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- StallE  in  1  EX stage stalled; holds all state and outputs.
- ValidE  in  1  EX holds a real (unsquashed) instruction.
- BranchInstE  in  1  decoder BranchInst, registered into EX.
- CondFlagE  in  3  decoder CondFlag, registered into EX.
- FlagWriteE  in  1  decoder FlagWrite, registered into EX.
- ALUFlagsE  in  4  {N,Z,C,V} from the ALU this cycle.
- PCE  in  WIDTH  address of the EX instruction.
- OffsetE  in  WIDTH  sign-extended branch offset in words.
- PCSrc  out  1  redirect fetch to PCTarget.
- PCTarget  out  WIDTH  branch target.
- FlushD  out  1  squash the decode stage.
- FlushE  out  1  squash the EX input register.
- Flags  out  4  current NZCV register.

Behaviour:
- Reset (rst=0 at an edge): Flags=4'b0000, PCSrc=0, PCTarget=0, FlushD=0, FlushE=0, FSM=IDLE, flush counter=0. Reset wins over all other inputs, including mid-flush.
- Condition codes, with {N,Z,C,V}=Flags register:
  - 000 AL: always taken.
  - 001 EQ: Z.
  - 010 NE: !Z.
  - 011 LT: N!=V.
  - 100 GT: !Z & (N==V).
  - 101 LE: Z | (N!=V).
  - 110 GE: N==V.
  - 111 NV: never taken.
- Flag register:
  - Updated at the edge when FlagWriteE & ValidE & !StallE & state==IDLE; takes ALUFlagsE.
  - A branch in the next EX cycle sees the new value. No same-cycle bypass is needed, because one instruction cannot both set flags and branch.
- Taken = BranchInstE & ValidE & !StallE & state==IDLE & cond(CondFlagE, Flags).
- Target = PCE + (OffsetE << 2), computed mod 2^WIDTH; wrap-around is silent.
- All outputs are registered; latency is 1 cycle from EX sample to redirect.
- FSM states: IDLE, FLUSH.
- IDLE:
  - If Taken: next cycle PCSrc=1, PCTarget=Target, FlushD=1, FlushE=1; go to FLUSH with counter=FLUSH_CYCLES-1.
  - Otherwise all pulses are 0 and PCTarget holds its last value.
- FLUSH:
  - PCSrc=0. FlushD=FlushE=1 while counter!=0, then decrement.
  - When counter==0, go to IDLE with all pulses 0.
  - BranchInstE and FlagWriteE are ignored in FLUSH, since those instructions are wrong-path.
- StallE=1 freezes the FSM, counter, Flags and all outputs, including a pulse already asserted (it stays asserted).
- A not-taken branch and NV cause no state change.
- ValidE=0 makes every EX input a don't-care.

Optional Feature: BRANCH_STATS_EN
- Defined:
  - Adds outputs BrCount[15:0] and TakenCount[15:0], both reset to 0.
  - BrCount increments on each evaluated branch (BranchInstE & ValidE & !StallE & IDLE).
  - TakenCount increments on each Taken.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 with BranchInstE=1, CondFlagE=000, ValidE=1 -> Flags=0, PCSrc=0, FlushD=0, FlushE=0 every cycle; release -> first AL branch redirects one cycle later.
- CMP then BEQ: FlagWriteE=1, ALUFlagsE=4'b0100; next cycle BranchInstE=1, CondFlagE=001, PCE=0x100, OffsetE=3 -> next cycle PCSrc=1, PCTarget=0x10C; FlushD/FlushE high for 2 cycles; PCSrc low after the first.
- Not taken: Flags=0000, CondFlagE=001 -> PCSrc=0, no flush. Also Flags=1000, CondFlagE=011 (LT) -> taken.
- Wrong-path squash: AL branch taken, then a BranchInstE=1 AL arrives during FLUSH -> no second PCSrc; a FlagWriteE in FLUSH leaves Flags unchanged.
- Stall mid-flush: assert StallE=1 for 3 cycles while in FLUSH -> outputs and counter frozen; flush completes after release, giving 2 total flush cycles.
- Wrap and stats: PCE=0xFFFFFFFC, OffsetE=1 -> PCTarget=0x0. With BRANCH_STATS_EN, 3 branches of which 2 are taken -> BrCount=3, TakenCount=2. Preloaded at 0xFFFF, the counters stay at 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Execute-stage branch resolution. Holds the architectural NZCV flag
//   register, evaluates the condition of the branch sitting in EX, computes
//   the branch target and, on a taken branch, issues a one-cycle PC redirect
//   followed by a bounded flush of the decode and EX input registers.
//
// Parameters:
//   WIDTH         PC / offset datapath width in bits.
//   FLUSH_CYCLES  number of cycles FlushD/FlushE stay high after a redirect
//                 (1..7). Branch and flag-write evaluation is suppressed for
//                 the same number of cycles.
//
// Optional build macro:
//   BRANCH_STATS_EN  adds BrCount / TakenCount saturating 16-bit counters.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-low reset
//   StallE       EX stalled: all state and outputs hold
//   ValidE       EX holds a real (unsquashed) instruction
//   BranchInstE  instruction in EX is a branch
//   CondFlagE    branch condition code (AL,EQ,NE,LT,GT,LE,GE,NV)
//   FlagWriteE   instruction in EX writes NZCV
//   ALUFlagsE    {N,Z,C,V} produced by the ALU this cycle
//   PCE          address of the EX instruction
//   OffsetE      sign-extended branch offset in words
//   PCSrc        redirect fetch to PCTarget (registered pulse)
//   PCTarget     branch target (holds when not redirecting)
//   FlushD       squash the decode stage
//   FlushE       squash the EX input register
//   Flags        current NZCV register
//   dbg_state    FSM state for observation (0 = IDLE, 1 = FLUSH)
//   BrCount      (BRANCH_STATS_EN) evaluated branches, saturating
//   TakenCount   (BRANCH_STATS_EN) taken branches, saturating
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallE,
    input  logic             ValidE,
    input  logic             BranchInstE,
    input  logic [2:0]       CondFlagE,
    input  logic             FlagWriteE,
    input  logic [3:0]       ALUFlagsE,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] OffsetE,
    output logic             PCSrc,
    output logic [WIDTH-1:0] PCTarget,
    output logic             FlushD,
    output logic             FlushE,
    output logic [3:0]       Flags,
    output logic             dbg_state
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      BrCount,
    output logic [15:0]      TakenCount
`endif
);

    // Handshake: an EX instruction is consumed at a rising edge exactly when
    // ValidE=1 and StallE=0. StallE acts as the inverse of ready: while it is
    // high nothing in this block advances, and outputs already asserted stay
    // asserted. With ValidE=0 every other EX input is ignored.

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             pcsrc_d;
    logic [WIDTH-1:0] target_d;
    logic             flushd_d;
    logic             flushe_d;
    logic [3:0]       flags_d;

    logic             flag_n, flag_z, flag_v;
    logic             cond_pass;
    logic             evaluate;
    logic             taken;
    logic [WIDTH-1:0] target;

    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_v = Flags[0];

    // Carry is held architecturally but no branch condition here reads it.
    always_comb begin
        cond_pass = 1'b0;
        case (CondFlagE)
            3'b000:  cond_pass = 1'b1;                          // AL
            3'b001:  cond_pass = flag_z;                        // EQ
            3'b010:  cond_pass = !flag_z;                       // NE
            3'b011:  cond_pass = (flag_n != flag_v);            // LT
            3'b100:  cond_pass = !flag_z && (flag_n == flag_v); // GT
            3'b101:  cond_pass = flag_z || (flag_n != flag_v);  // LE
            3'b110:  cond_pass = (flag_n == flag_v);            // GE
            default: cond_pass = 1'b0;                          // NV
        endcase
    end

    // Word offset -> byte offset; wrap-around is intentionally silent.
    assign target   = PCE + (OffsetE << 2);

    // Only instructions consumed while IDLE are on the correct path.
    assign evaluate = BranchInstE && ValidE && !StallE && (state_q == IDLE);
    assign taken    = evaluate && cond_pass;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pcsrc_d  = PCSrc;
        target_d = PCTarget;
        flushd_d = FlushD;
        flushe_d = FlushE;
        flags_d  = Flags;

        case (state_q)
            IDLE: begin
                pcsrc_d  = 1'b0;
                flushd_d = 1'b0;
                flushe_d = 1'b0;
                if (FlagWriteE && ValidE) begin
                    flags_d = ALUFlagsE;
                end
                if (taken) begin
                    pcsrc_d  = 1'b1;
                    target_d = target;
                    flushd_d = 1'b1;
                    flushe_d = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                // The redirect cycle already counted as the first flush
                // cycle; the counter covers the remaining ones.
                pcsrc_d = 1'b0;
                if (cnt_q != 3'd0) begin
                    flushd_d = 1'b1;
                    flushe_d = 1'b1;
                    cnt_d    = cnt_q - 3'd1;
                end else begin
                    flushd_d = 1'b0;
                    flushe_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                pcsrc_d  = 1'b0;
                flushd_d = 1'b0;
                flushe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            PCSrc    <= 1'b0;
            PCTarget <= '0;
            FlushD   <= 1'b0;
            FlushE   <= 1'b0;
            Flags    <= 4'b0000;
        end else if (!StallE) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            PCSrc    <= pcsrc_d;
            PCTarget <= target_d;
            FlushD   <= flushd_d;
            FlushE   <= flushe_d;
            Flags    <= flags_d;
        end
    end

    assign dbg_state = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            BrCount    <= 16'h0000;
            TakenCount <= 16'h0000;
        end else begin
            if (evaluate && (BrCount != 16'hFFFF)) begin
                BrCount <= BrCount + 16'd1;
            end
            if (taken && (TakenCount != 16'hFFFF)) begin
                TakenCount <= TakenCount + 16'd1;
            end
        end
    end
`endif

endmodule
